// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: program-ROM address/data plus branch redirect and the
// instruction stream to decode.
interface inst_fetch_unit_if;
    logic [23:0] pc_addr_o;
    logic [23:0] rom_inst_i;
    logic        branch_valid_i;
    logic [23:0] branch_target_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [23:0] inst_o;
    logic [23:0] inst_pc_o;

    // Decode stream: an instruction transfers on any cycle with inst_valid_o &
    // inst_ready_i; while valid & ~ready, inst_o/inst_pc_o hold steady until taken.
    modport master (
        output pc_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  rom_inst_i, branch_valid_i, branch_target_i, inst_ready_i
    );

    modport slave (
        input  pc_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output rom_inst_i, branch_valid_i, branch_target_i, inst_ready_i
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// PIC24 instruction fetch: drives the ROM address, tags returned words with their PC.
// Optional accepted-instruction counter enabled by INST_FETCH_PERF_CNT_EN.
module inst_fetch_unit #(
    parameter logic [23:0] RESET_VECTOR = 24'h000000,
    parameter logic [23:0] PC_LIMIT     = 24'h7FFFFE
) (
    input  logic               clk_i,
    input  logic               rst_ni,
`ifdef INST_FETCH_PERF_CNT_EN
    output logic [31:0]        inst_count_o,
`endif
    inst_fetch_unit_if.master  bus
);

    function automatic logic [23:0] inc(input logic [23:0] x);
        return (x == PC_LIMIT) ? 24'h000000 : x + 24'd2;
    endfunction

    logic [23:0] fetch_pc_q, fetch_pc_d;
    logic        f2_valid_q, f2_valid_d;
    logic [23:0] f2_pc_q, f2_pc_d;
    logic [23:0] pc_addr;
    logic [23:0] tgt;
    logic        stall;
    logic        inst_valid;

    // Clearing bit 23 folds any out-of-range target back into user space.
    assign tgt        = {1'b0, bus.branch_target_i[22:1], 1'b0};
    assign stall      = f2_valid_q & ~bus.inst_ready_i;
    assign inst_valid = f2_valid_q & ~bus.branch_valid_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        f2_valid_d = f2_valid_q;
        f2_pc_d    = f2_pc_q;
        pc_addr    = fetch_pc_q;
        if (bus.branch_valid_i) begin
            pc_addr    = tgt;
            f2_valid_d = 1'b1;
            f2_pc_d    = tgt;
            fetch_pc_d = inc(tgt);
        end else if (stall) begin
            // Replaying the held address keeps the ROM word stable next cycle.
            pc_addr = f2_pc_q;
        end else begin
            f2_valid_d = 1'b1;
            f2_pc_d    = fetch_pc_q;
            fetch_pc_d = inc(fetch_pc_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_VECTOR;
            f2_valid_q <= 1'b0;
            f2_pc_q    <= 24'h000000;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            f2_valid_q <= f2_valid_d;
            f2_pc_q    <= f2_pc_d;
        end
    end

    assign bus.pc_addr_o    = pc_addr;
    assign bus.inst_valid_o = inst_valid;
    assign bus.inst_o       = bus.rom_inst_i;
    assign bus.inst_pc_o    = f2_pc_q;

`ifdef INST_FETCH_PERF_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 32'h0;
        end else if (inst_valid && bus.inst_ready_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign inst_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: stream-order model checked every cycle plus
// directed literal checks for each scenario.
module tb_inst_fetch_unit;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk_i = ~clk_i;

    inst_fetch_unit_if bus ();

`ifdef INST_FETCH_PERF_CNT_EN
    logic [31:0] inst_count_o;
`endif

    inst_fetch_unit dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
`ifdef INST_FETCH_PERF_CNT_EN
        .inst_count_o (inst_count_o),
`endif
        .bus          (bus)
    );

    function automatic logic [23:0] rom_fn(input logic [23:0] a);
        return {a[23:16] ^ 8'hC3, a[15:0]};
    endfunction

    function automatic logic [23:0] nxt(input logic [23:0] a);
        return (a == 24'h7FFFFE) ? 24'h000000 : a + 24'd2;
    endfunction

    // Program ROM: registered read, output cleared while held in reset.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) bus.rom_inst_i <= 24'h0;
        else         bus.rom_inst_i <= rom_fn(bus.pc_addr_o);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stream must deliver exp_pc next, then its successors in order.
    logic        m_started = 1'b0;
    logic [23:0] m_exp_pc = 24'h0;
    logic [31:0] m_count = 32'h0;

    always @(negedge clk_i) begin
        logic        exp_valid;
        logic [23:0] exp_addr;
        logic [23:0] san;
        if (!rst_ni) begin
            chk("rst_valid", {31'b0, bus.inst_valid_o}, 32'd0);
            chk("rst_addr", {8'h0, bus.pc_addr_o}, 32'h0);
            chk("rst_inst_pc", {8'h0, bus.inst_pc_o}, 32'h0);
            chk("rst_inst", {8'h0, bus.inst_o}, 32'h0);
            m_started = 1'b0;
            m_exp_pc  = 24'h0;
            m_count   = 32'h0;
        end else begin
            san       = bus.branch_target_i & 24'h7FFFFE;
            exp_valid = m_started && !bus.branch_valid_i;
            chk("m_valid", {31'b0, bus.inst_valid_o}, {31'b0, exp_valid});
            if (exp_valid) begin
                chk("m_inst_pc", {8'h0, bus.inst_pc_o}, {8'h0, m_exp_pc});
                chk("m_inst", {8'h0, bus.inst_o}, {8'h0, rom_fn(m_exp_pc)});
            end
            if (bus.branch_valid_i)                 exp_addr = san;
            else if (exp_valid && bus.inst_ready_i) exp_addr = nxt(m_exp_pc);
            else                                    exp_addr = m_exp_pc;
            chk("m_pc_addr", {8'h0, bus.pc_addr_o}, {8'h0, exp_addr});
`ifdef INST_FETCH_PERF_CNT_EN
            chk("m_count", inst_count_o, m_count);
`endif
            if (exp_valid && bus.inst_ready_i && m_count != 32'hFFFF_FFFF) m_count++;
            if (bus.branch_valid_i)                 m_exp_pc = san;
            else if (exp_valid && bus.inst_ready_i) m_exp_pc = nxt(m_exp_pc);
            m_started = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [23:0] addr, input logic valid,
                           input logic [23:0] ipc);
        chk({name, "_addr"}, {8'h0, bus.pc_addr_o}, {8'h0, addr});
        chk({name, "_valid"}, {31'b0, bus.inst_valid_o}, {31'b0, valid});
        if (valid) chk({name, "_pc"}, {8'h0, bus.inst_pc_o}, {8'h0, ipc});
    endtask

    logic [11:0] ready_pat = 12'b1011_0010_1101;

    initial begin
        bus.inst_ready_i    = 1'b1;
        bus.branch_valid_i  = 1'b0;
        bus.branch_target_i = 24'h0;
        repeat (3) cyc();
        rst_ni = 1'b1;

        // Sequential fetch from reset
        smp(); chk_out("s1_c0", 24'h000000, 1'b0, 24'h0);
        cyc(); smp(); chk_out("s1_c1", 24'h000002, 1'b1, 24'h000000);
        chk("s1_inst0", {8'h0, bus.inst_o}, 32'h00C30000);
        cyc(); smp(); chk_out("s1_c2", 24'h000004, 1'b1, 24'h000002);
        chk("s1_inst2", {8'h0, bus.inst_o}, 32'h00C30002);
        cyc(); smp(); chk_out("s1_c3", 24'h000006, 1'b1, 24'h000004);

        // Stall three cycles on PC 6
        cyc(); bus.inst_ready_i = 1'b0;
        smp(); chk_out("s2_st0", 24'h000006, 1'b1, 24'h000006);
        cyc(); smp(); chk_out("s2_st1", 24'h000006, 1'b1, 24'h000006);
        cyc(); smp(); chk_out("s2_st2", 24'h000006, 1'b1, 24'h000006);
        chk("s2_inst", {8'h0, bus.inst_o}, 32'h00C30006);
        cyc(); bus.inst_ready_i = 1'b1;
        smp(); chk_out("s2_rel", 24'h000008, 1'b1, 24'h000006);
        cyc(); smp(); chk_out("s2_next", 24'h00000A, 1'b1, 24'h000008);

        // Branch while streaming, odd target
        cyc(); bus.branch_valid_i = 1'b1; bus.branch_target_i = 24'h000101;
        smp(); chk_out("s3_br", 24'h000100, 1'b0, 24'h0);
        cyc(); bus.branch_valid_i = 1'b0;
        smp(); chk_out("s3_t0", 24'h000102, 1'b1, 24'h000100);
        cyc(); smp(); chk_out("s3_t1", 24'h000104, 1'b1, 24'h000102);

        // Branch during a stall
        cyc(); bus.inst_ready_i = 1'b0;
        smp(); chk_out("s4_st", 24'h000104, 1'b1, 24'h000104);
        cyc(); smp(); chk_out("s4_st1", 24'h000104, 1'b1, 24'h000104);
        cyc(); bus.branch_valid_i = 1'b1; bus.branch_target_i = 24'h000200;
        smp(); chk_out("s4_br", 24'h000200, 1'b0, 24'h0);
        cyc(); bus.branch_valid_i = 1'b0; bus.inst_ready_i = 1'b1;
        smp(); chk_out("s4_t0", 24'h000202, 1'b1, 24'h000200);
        chk("s4_inst", {8'h0, bus.inst_o}, 32'h00C30200);

        // Wrap at PC_LIMIT, folded target
        cyc(); bus.branch_valid_i = 1'b1; bus.branch_target_i = 24'hFFFFFE;
        smp(); chk_out("s5_fold", 24'h7FFFFE, 1'b0, 24'h0);
        cyc(); bus.branch_valid_i = 1'b0;
        smp(); chk_out("s5_lim", 24'h000000, 1'b1, 24'h7FFFFE);
        chk("s5_inst", {8'h0, bus.inst_o}, 32'h00BCFFFE);
        cyc(); smp(); chk_out("s5_wrap", 24'h000002, 1'b1, 24'h000000);
        cyc(); bus.branch_valid_i = 1'b1; bus.branch_target_i = 24'h7FFFFE;
        smp(); chk_out("s5_br2", 24'h7FFFFE, 1'b0, 24'h0);
        cyc(); bus.branch_valid_i = 1'b0;
        smp(); chk_out("s5_lim2", 24'h000000, 1'b1, 24'h7FFFFE);
        cyc(); smp(); chk_out("s5_wrap2", 24'h000002, 1'b1, 24'h000000);

        // Irregular ready pattern, checked by the model
        for (int i = 0; i < 12; i++) begin
            cyc(); bus.inst_ready_i = ready_pat[i];
        end
        cyc(); bus.inst_ready_i = 1'b1;
        cyc();

        // Asynchronous reset mid-cycle
        #2 rst_ni = 1'b0;
        #1;
        chk_out("s6_rst", 24'h000000, 1'b0, 24'h0);
        chk("s6_rst_valid", {31'b0, bus.inst_valid_o}, 32'd0);
`ifdef INST_FETCH_PERF_CNT_EN
        chk("s6_cnt_rst", inst_count_o, 32'd0);
`endif
        repeat (2) cyc();
        rst_ni = 1'b1;
        smp(); chk_out("s6_c0", 24'h000000, 1'b0, 24'h0);
        cyc(); smp(); chk_out("s6_c1", 24'h000002, 1'b1, 24'h000000);
`ifdef INST_FETCH_PERF_CNT_EN
        chk("s6_cnt0", inst_count_o, 32'd0);
        cyc(); smp(); chk("s6_cnt1", inst_count_o, 32'd1);
`endif
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
